// File: rtl/alu_issue_if.sv
// Request/ALU/response signal bundle for the alu_issue sequencer.
// The slave modport is the sequencer's view; master is the view of whatever
// surrounds it (requester, ALU and response consumer together).
interface alu_issue_if #(
    parameter int CNT_W = 8
);
    // request side
    logic             req_valid;
    logic             req_ready;
    logic [5:0]       req_funct;
    logic [31:0]      req_a;
    logic [31:0]      req_b;

    // ALU side
    logic [2:0]       ALU_OP;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [31:0]      alu_f;
    logic             alu_zf;
    logic             alu_of;

    // response side
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_f;
    logic             rsp_zf;
    logic             rsp_of;
    logic             rsp_err;

    // status
    logic             of_sticky;
    logic             of_clr;
    logic [CNT_W-1:0] op_count;

    modport slave (
        input  req_valid, req_funct, req_a, req_b,
        input  alu_f, alu_zf, alu_of,
        input  rsp_ready, of_clr,
        output req_ready,
        output ALU_OP, alu_a, alu_b,
        output rsp_valid, rsp_f, rsp_zf, rsp_of, rsp_err,
        output of_sticky, op_count
    );

    modport master (
        output req_valid, req_funct, req_a, req_b,
        output alu_f, alu_zf, alu_of,
        output rsp_ready, of_clr,
        input  req_ready,
        input  ALU_OP, alu_a, alu_b,
        input  rsp_valid, rsp_f, rsp_zf, rsp_of, rsp_err,
        input  of_sticky, op_count
    );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: accepts one MIPS R-type request at a time, decodes the funct
// code, drives an external ALU from registers for one EXEC cycle, captures
// the result and presents it until the consumer takes it.
// Illegal funct codes skip the ALU entirely and answer with rsp_err=1.
module alu_issue #(
    parameter int CNT_W = 8
) (
    input  logic      clk,
    input  logic      rst,
    alu_issue_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    // Decode table, entry i holds the funct code whose ALU_OP is i.
    // Entry 0 sits in the least significant six bits.
    localparam logic [47:0] FUNCT_TABLE = {
        6'b000100,   // 7 SLLV
        6'b101011,   // 6 SLTU
        6'b100010,   // 5 SUB
        6'b100000,   // 4 ADD
        6'b100111,   // 3 NOR
        6'b100110,   // 2 XOR
        6'b100101,   // 1 OR
        6'b100100    // 0 AND
    };

    state_t           state_reg;
    logic             ready_reg;
    logic             valid_reg;
    logic [2:0]       op_reg;
    logic [31:0]      a_reg;
    logic [31:0]      b_reg;
    logic [31:0]      rsp_f_reg;
    logic             rsp_zf_reg;
    logic             rsp_of_reg;
    logic             rsp_err_reg;
    logic             sticky_reg;
    logic [CNT_W-1:0] count_reg;

    logic [7:0]       funct_hit;
    logic             decode_legal;
    logic [2:0]       decode_op;
    logic             capture_of;

    // One comparator per table entry; at most one can match.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_decode
            assign funct_hit[gi] = (bus.req_funct == FUNCT_TABLE[gi*6 +: 6]);
        end
    endgenerate

    // Encode the one-hot match into the ALU opcode.
    always_comb begin
        decode_op    = 3'b000;
        decode_legal = |funct_hit;
        for (int i = 0; i < 8; i++) begin
            if (funct_hit[i]) begin
                decode_op = 3'(i);
            end
        end
    end

    // Overflow only has meaning for the arithmetic operations.
    assign capture_of = bus.alu_of && ((op_reg == OP_ADD) || (op_reg == OP_SUB));

    // Sequencer FSM; every output it owns is a register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            ready_reg   <= 1'b1;
            valid_reg   <= 1'b0;
            op_reg      <= 3'b000;
            a_reg       <= '0;
            b_reg       <= '0;
            rsp_f_reg   <= '0;
            rsp_zf_reg  <= 1'b0;
            rsp_of_reg  <= 1'b0;
            rsp_err_reg <= 1'b0;
            count_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid) begin
                        ready_reg <= 1'b0;
                        if (decode_legal) begin
                            // ALU inputs change only on a legal acceptance
                            op_reg    <= decode_op;
                            a_reg     <= bus.req_a;
                            b_reg     <= bus.req_b;
                            state_reg <= EXEC;
                        end else begin
                            rsp_f_reg   <= '0;
                            rsp_zf_reg  <= 1'b0;
                            rsp_of_reg  <= 1'b0;
                            rsp_err_reg <= 1'b1;
                            valid_reg   <= 1'b1;
                            state_reg   <= RESP;
                        end
                    end
                end
                EXEC: begin
                    rsp_f_reg   <= bus.alu_f;
                    rsp_zf_reg  <= bus.alu_zf;
                    rsp_of_reg  <= capture_of;
                    rsp_err_reg <= 1'b0;
                    valid_reg   <= 1'b1;
                    state_reg   <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        valid_reg <= 1'b0;
                        ready_reg <= 1'b1;
                        count_reg <= count_reg + 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Sticky overflow: a capture with overflow beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_reg <= 1'b0;
        end else if ((state_reg == EXEC) && capture_of) begin
            sticky_reg <= 1'b1;
        end else if (bus.of_clr) begin
            sticky_reg <= 1'b0;
        end
    end

    assign bus.req_ready = ready_reg;
    assign bus.ALU_OP    = op_reg;
    assign bus.alu_a     = a_reg;
    assign bus.alu_b     = b_reg;
    assign bus.rsp_valid = valid_reg;
    assign bus.rsp_f     = rsp_f_reg;
    assign bus.rsp_zf    = rsp_zf_reg;
    assign bus.rsp_of    = rsp_of_reg;
    assign bus.rsp_err   = rsp_err_reg;
    assign bus.of_sticky = sticky_reg;
    assign bus.op_count  = count_reg;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: the bench plays the ALU, the requester
// and the consumer, predicts every response from the funct/operand rules
// and compares the DUT against that prediction each cycle.
module tb_alu_issue;

    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic inject_of = 1'b0;

    always #5 clk = ~clk;

    alu_issue_if #(.CNT_W(CNT_W)) bus ();

    alu_issue #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- bench-side ALU ----------------
    logic [31:0] alu_res;
    logic        alu_ovf;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.ALU_OP)
            3'd0: alu_res = bus.alu_a & bus.alu_b;
            3'd1: alu_res = bus.alu_a | bus.alu_b;
            3'd2: alu_res = bus.alu_a ^ bus.alu_b;
            3'd3: alu_res = ~(bus.alu_a | bus.alu_b);
            3'd4: begin
                alu_res = bus.alu_a + bus.alu_b;
                alu_ovf = (bus.alu_a[31] == bus.alu_b[31]) && (alu_res[31] != bus.alu_a[31]);
            end
            3'd5: begin
                alu_res = bus.alu_a - bus.alu_b;
                alu_ovf = (bus.alu_a[31] != bus.alu_b[31]) && (alu_res[31] != bus.alu_a[31]);
            end
            3'd6: alu_res = {31'd0, (bus.alu_a < bus.alu_b)};
            default: alu_res = bus.alu_a << bus.alu_b[4:0];
        endcase
    end

    assign bus.alu_f  = alu_res;
    assign bus.alu_zf = (alu_res == 32'd0);
    assign bus.alu_of = alu_ovf | inject_of;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        legal;
        logic [2:0]  op;
        logic [31:0] f;
        logic        zf;
        logic        of;
        logic        err;
    } exp_t;

    function automatic exp_t ref_model(input logic [5:0] funct, input logic [31:0] a,
                                       input logic [31:0] b, input logic inj);
        exp_t   e;
        longint sa   = longint'($signed(a));
        longint sb   = longint'($signed(b));
        longint maxv = 2147483647;
        longint minv = -maxv - 1;
        longint r;
        logic   ovf  = 1'b0;
        e.legal = 1'b1;
        e.op    = 3'd0;
        e.f     = 32'd0;
        case (funct)
            6'b100100: begin e.op = 3'd0; e.f = a & b;    end
            6'b100101: begin e.op = 3'd1; e.f = a | b;    end
            6'b100110: begin e.op = 3'd2; e.f = a ^ b;    end
            6'b100111: begin e.op = 3'd3; e.f = ~(a | b); end
            6'b100000: begin
                e.op = 3'd4; e.f = a + b;
                r = sa + sb; ovf = (r > maxv) || (r < minv);
            end
            6'b100010: begin
                e.op = 3'd5; e.f = a - b;
                r = sa - sb; ovf = (r > maxv) || (r < minv);
            end
            6'b101011: begin e.op = 3'd6; e.f = (a < b) ? 32'd1 : 32'd0; end
            6'b000100: begin e.op = 3'd7; e.f = a << b[4:0]; end
            default:   e.legal = 1'b0;
        endcase
        e.zf  = e.legal && (e.f == 32'd0);
        e.of  = e.legal && ((e.op == 3'd4) || (e.op == 3'd5)) && (ovf || inj);
        e.err = !e.legal;
        return e;
    endfunction

    exp_t             exp_q[$];
    logic [CNT_W-1:0] model_count  = '0;
    logic             model_sticky = 1'b0;
    logic [2:0]       prev_op      = 3'd0;

    int tests_run = 0;
    int fails     = 0;

    logic [31:0] got_f;
    logic        got_zf, got_of, got_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            chk("op_count", 32'(bus.op_count), 32'(model_count));
            chk("of_sticky", 32'(bus.of_sticky), 32'(model_sticky));
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    fails++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 required rsp_valid=0 at %0t", $time);
                end else begin
                    chk("rsp_f",   bus.rsp_f,            exp_q[0].f);
                    chk("rsp_zf",  32'(bus.rsp_zf),      32'(exp_q[0].zf));
                    chk("rsp_of",  32'(bus.rsp_of),      32'(exp_q[0].of));
                    chk("rsp_err", 32'(bus.rsp_err),     32'(exp_q[0].err));
                    chk("resp_req_ready", 32'(bus.req_ready), 32'd0);
                end
            end
        end
    end

    // ---------------- driver tasks (start and end at a falling edge) ----------------
    task automatic do_op(input logic [5:0] funct, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input logic inj, input logic clr_cap, input logic junk);
        exp_t e;
        e = ref_model(funct, a, b, inj);
        chk("idle_req_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_funct = funct;
        bus.req_a     = a;
        bus.req_b     = b;
        inject_of     = inj;
        exp_q.push_back(e);
        @(posedge clk);                      // acceptance edge N
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_funct = 6'($urandom);
        bus.req_a     = $urandom;
        bus.req_b     = $urandom;
        if (e.legal) begin
            chk("exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("exec_req_ready", 32'(bus.req_ready), 32'd0);
            chk("exec_alu_op",    32'(bus.ALU_OP),    32'(e.op));
            chk("exec_alu_a",     bus.alu_a,          a);
            chk("exec_alu_b",     bus.alu_b,          b);
            bus.of_clr = clr_cap;
            @(posedge clk);                  // capture edge N+1
            if (clr_cap) model_sticky = 1'b0;
            if (e.of)    model_sticky = 1'b1;
            @(negedge clk);
            bus.of_clr = 1'b0;
            prev_op = e.op;
        end else begin
            chk("illegal_alu_op", 32'(bus.ALU_OP), 32'(prev_op));
        end
        chk("latency_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        got_f   = bus.rsp_f;
        got_zf  = bus.rsp_zf;
        got_of  = bus.rsp_of;
        got_err = bus.rsp_err;
        for (int k = 0; k < hold; k++) begin
            bus.rsp_ready = 1'b0;
            if (junk) begin
                bus.req_valid = 1'b1;
                bus.req_funct = 6'b100000;
                bus.req_a     = $urandom;
                bus.req_b     = $urandom;
            end
            @(posedge clk);
            @(negedge clk);
            chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);                      // handshake edge
        void'(exp_q.pop_front());
        model_count = model_count + 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        inject_of     = 1'b0;
        chk("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("post_req_ready", 32'(bus.req_ready), 32'd1);
        $display("[TB] op funct=%b a=%08h b=%08h hold=%0d inj=%0d -> f=%08h zf=%0d of=%0d err=%0d",
                 funct, a, b, hold, inj, got_f, got_zf, got_of, got_err);
    endtask

    task automatic clear_sticky();
        bus.of_clr = 1'b1;
        @(posedge clk);
        model_sticky = 1'b0;
        @(negedge clk);
        bus.of_clr = 1'b0;
    endtask

    task automatic check_reset_vals();
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_f",     bus.rsp_f,          32'd0);
        chk("rst_rsp_zf",    32'(bus.rsp_zf),    32'd0);
        chk("rst_rsp_of",    32'(bus.rsp_of),    32'd0);
        chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
        chk("rst_alu_op",    32'(bus.ALU_OP),    32'd0);
        chk("rst_alu_a",     bus.alu_a,          32'd0);
        chk("rst_alu_b",     bus.alu_b,          32'd0);
        chk("rst_of_sticky", 32'(bus.of_sticky), 32'd0);
        chk("rst_op_count",  32'(bus.op_count),  32'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] edges [5];
        edges[0] = 32'h0000_0000;
        edges[1] = 32'h0000_0001;
        edges[2] = 32'h7FFF_FFFF;
        edges[3] = 32'h8000_0000;
        edges[4] = 32'hFFFF_FFFF;
        if ($urandom_range(3) == 0) return edges[$urandom_range(4)];
        return $urandom;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] legal_tab [8];
        logic [5:0] f;
        legal_tab[0] = 6'b100100; legal_tab[1] = 6'b100101;
        legal_tab[2] = 6'b100110; legal_tab[3] = 6'b100111;
        legal_tab[4] = 6'b100000; legal_tab[5] = 6'b100010;
        legal_tab[6] = 6'b101011; legal_tab[7] = 6'b000100;

        bus.req_valid = 1'b0;
        bus.req_funct = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        bus.of_clr    = 1'b0;

        repeat (2) @(negedge clk);
        check_reset_vals();
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);

        // ADD overflow
        do_op(6'b100000, 32'h7FFF_FFFF, 32'h0000_0001, 0, 1'b0, 1'b0, 1'b0);
        chk("add_ovf_f",      got_f,               32'h8000_0000);
        chk("add_ovf_of",     32'(got_of),         32'd1);
        chk("add_ovf_zf",     32'(got_zf),         32'd0);
        chk("add_ovf_sticky", 32'(bus.of_sticky),  32'd1);
        chk("add_ovf_count",  32'(bus.op_count),   32'd1);

        // SUB to zero
        do_op(6'b100010, 32'd5, 32'd5, 1, 1'b0, 1'b0, 1'b0);
        chk("sub_zero_f",   got_f,            32'd0);
        chk("sub_zero_zf",  32'(got_zf),      32'd1);
        chk("sub_zero_err", 32'(got_err),     32'd0);
        chk("sub_alu_op",   32'(bus.ALU_OP),  32'd5);

        // illegal funct
        do_op(6'b001000, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b0, 1'b0, 1'b0);
        chk("illegal_err",    32'(got_err),     32'd1);
        chk("illegal_f",      got_f,            32'd0);
        chk("illegal_alu_op_lit", 32'(bus.ALU_OP), 32'd5);
        chk("illegal_count",  32'(bus.op_count), 32'd3);

        // SLTU held five cycles with a stray request during the hold
        do_op(6'b101011, 32'd3, 32'd7, 5, 1'b0, 1'b0, 1'b1);
        chk("sltu_f",     got_f,             32'd1);
        chk("sltu_count", 32'(bus.op_count), 32'd4);

        // overflow flag masking and sticky behaviour
        do_op(6'b100110, 32'hF0F0_0000, 32'h0F0F_0000, 0, 1'b1, 1'b0, 1'b0);
        chk("xor_of_masked",  32'(got_of),        32'd0);
        chk("xor_sticky_kept", 32'(bus.of_sticky), 32'd1);
        clear_sticky();
        chk("sticky_cleared", 32'(bus.of_sticky), 32'd0);
        do_op(6'b100110, 32'h0000_00FF, 32'h0000_0F0F, 0, 1'b1, 1'b0, 1'b0);
        chk("xor_sticky_zero", 32'(bus.of_sticky), 32'd0);
        do_op(6'b100000, 32'h8000_0000, 32'h8000_0000, 0, 1'b0, 1'b1, 1'b0);
        chk("set_beats_clr", 32'(bus.of_sticky), 32'd1);

        // reset in the middle of an ADD
        bus.req_valid = 1'b1;
        bus.req_funct = 6'b100000;
        bus.req_a     = 32'h7FFF_FFFF;
        bus.req_b     = 32'h0000_0001;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("pre_rst_exec_op", 32'(bus.ALU_OP), 32'd4);
        #2 rst = 1'b1;
        exp_q.delete();
        model_count  = '0;
        model_sticky = 1'b0;
        prev_op      = 3'd0;
        #1 check_reset_vals();
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("abandon_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        end
        chk("abandon_req_ready", 32'(bus.req_ready), 32'd1);
        do_op(6'b100000, 32'd2, 32'd3, 0, 1'b0, 1'b0, 1'b0);
        chk("after_rst_f",     got_f,             32'd5);
        chk("after_rst_count", 32'(bus.op_count), 32'd1);

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(3) != 0) f = legal_tab[$urandom_range(7)];
            else                        f = 6'($urandom);
            do_op(f, pick_operand(), pick_operand(), int'($urandom_range(3)),
                  ($urandom_range(3) == 0), ($urandom_range(5) == 0), ($urandom_range(3) == 0));
            if ($urandom_range(7) == 0) clear_sticky();
            if ($urandom_range(4) == 0) repeat ($urandom_range(3)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
